// File: rtl/mips_enc_pkg.sv
// Shared types and constants for the MIPS instruction encoder.
// Holds the op enum, opcode/funct constants and the FSM state type.
package mips_enc_pkg;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'd0,
    OP_JR    = 4'd1,
    OP_J     = 4'd2,
    OP_JAL   = 4'd3,
    OP_ADDI  = 4'd4,
    OP_ANDI  = 4'd5,
    OP_ORI   = 4'd6,
    OP_BEQ   = 4'd7,
    OP_BNE   = 4'd8,
    OP_LW    = 4'd9,
    OP_SW    = 4'd10,
    OP_SLTI  = 4'd11
  } op_t;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_SLTI    = 6'b001010;

  localparam logic [5:0] FUNCT_JR    = 6'b001000;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCEPT = 2'd1;
  localparam state_t S_WRITE  = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/instr_enc_core.sv
// Combinational field-to-word mapping for R, I and J formats.
// Unknown ops yield a zero word and raise illegal.
module instr_enc_core
  import mips_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: word = {OPC_SPECIAL, rs, rt, rd, 5'd0, funct};
      OP_JR:    word = {OPC_SPECIAL, rs, 15'd0, FUNCT_JR};
      OP_J:     word = {OPC_J, target};
      OP_JAL:   word = {OPC_JAL, target};
      OP_ADDI:  word = {OPC_ADDI, rs, rt, imm};
      OP_ANDI:  word = {OPC_ANDI, rs, rt, imm};
      OP_ORI:   word = {OPC_ORI, rs, rt, imm};
      OP_BEQ:   word = {OPC_BEQ, rs, rt, imm};
      OP_BNE:   word = {OPC_BNE, rs, rt, imm};
      OP_LW:    word = {OPC_LW, rs, rt, imm};
      OP_SW:    word = {OPC_SW, rs, rt, imm};
      OP_SLTI:  word = {OPC_SLTI, rs, rt, imm};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes a stream of op requests and writes them to instruction memory.
// Optional ENC_ILLEGAL_CHECK_EN skips illegal ops and flags err.
module instr_encoder
  import mips_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] count,
  output logic        err
);

  state_t      state;
  logic        last_q;
  logic [31:0] word;
  logic        illegal;

  instr_enc_core u_core (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

`ifdef ENC_ILLEGAL_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Handshake outputs decode straight from state so reset drops them at once
  assign in_ready = (state == S_ACCEPT);
  assign mem_we   = (state == S_WRITE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      last_q    <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr <= base_addr;
            count    <= '0;
`ifdef ENC_ILLEGAL_CHECK_EN
            err_q    <= 1'b0;
`endif
            state    <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
`ifdef ENC_ILLEGAL_CHECK_EN
            if (illegal) begin
              err_q <= 1'b1;
              state <= in_last ? S_DONE : S_ACCEPT;
            end else
`endif
            begin
              // Illegal ops fall through as a nop word
              mem_wdata <= illegal ? 32'h0 : word;
              last_q    <= in_last;
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + 32'd4;
            if (count != 16'hFFFF)
              count <= count + 16'd1;
            state <= last_q ? S_DONE : S_ACCEPT;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed words.
// Build with ENC_ILLEGAL_CHECK_EN to check the illegal-skip path.
module tb_instr_encoder;
  import mips_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [15:0] count;
  logic        err;

  int errs = 0;
  int checks = 0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_funct  (in_funct),
    .in_imm    (in_imm),
    .in_target (in_target),
    .in_last   (in_last),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] w;
  } vec_t;

  vec_t iv[6];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", {31'd0, in_ready}, 32'd1);
    check("start_addr", mem_addr, b);
    check("start_count", {16'd0, count}, 32'd0);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [5:0] fn, input logic [15:0] imm,
                      input logic [25:0] tg, input logic lst);
    in_op = op;
    in_rs = rs;
    in_rt = rt;
    in_rd = rd;
    in_funct = fn;
    in_imm = imm;
    in_target = tg;
    in_last = lst;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a,
                              input logic [31:0] d, input int dly);
    int n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_data"}, mem_wdata, d);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check({tag, "_hold_we"}, {31'd0, mem_we}, 32'd1);
      check({tag, "_hold_data"}, mem_wdata, d);
      check({tag, "_hold_addr"}, mem_addr, a);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check({tag, "_next"}, mem_addr, a + 32'd4);
  endtask

  task automatic expect_done(input string tag, input logic [15:0] cnt);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_count"}, {16'd0, count}, {16'd0, cnt});
    @(negedge clk);
    check({tag, "_done_end"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    iv[0] = '{OP_ANDI, 5'd3,  5'd4,  16'hFFFF, 32'h3064FFFF};
    iv[1] = '{OP_ORI,  5'd0,  5'd5,  16'h8000, 32'h34058000};
    iv[2] = '{OP_BEQ,  5'd1,  5'd2,  16'hFFFE, 32'h1022FFFE};
    iv[3] = '{OP_BNE,  5'd4,  5'd5,  16'h0003, 32'h14850003};
    iv[4] = '{OP_SLTI, 5'd2,  5'd3,  16'h7FFF, 32'h28437FFF};
    iv[5] = '{OP_SW,   5'd29, 5'd31, 16'h0008, 32'hAFBF0008};

    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_op = '0;
    in_rs = '0;
    in_rt = '0;
    in_rd = '0;
    in_funct = '0;
    in_imm = '0;
    in_target = '0;
    in_last = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ctl", {26'd0, mem_we, in_ready, busy, done, err, 1'b0}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd0);

    // ADDI single word
    do_start(32'h0040_0000);
    send(OP_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1);
    expect_write("addi", 32'h0040_0000, 32'h2022_0005, 0);
    expect_done("addi", 16'd1);

    // RTYPE + JR, with stray mem_ack ignored in ACCEPT
    do_start(32'h0000_1000);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ack_ignored", mem_addr, 32'h0000_1000);
    check("ack_ignored_cnt", {16'd0, count}, 32'd0);
    send(OP_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'd0, 1'b0);
    expect_write("rtype", 32'h0000_1000, 32'h0022_1820, 0);
    check("rtype_ready", {31'd0, in_ready}, 32'd1);
    send(OP_JR, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b1);
    expect_write("jr", 32'h0000_1004, 32'h03E0_0008, 0);
    expect_done("jr", 16'd2);

    // J + JAL with delayed ack; start mid-load is ignored
    do_start(32'h0000_2000);
    send(OP_J, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b0);
    start = 1'b1;
    base_addr = 32'hDEAD_0000;
    expect_write("j", 32'h0000_2000, 32'h0800_0010, 3);
    start = 1'b0;
    send(OP_JAL, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b1);
    expect_write("jal", 32'h0000_2004, 32'h0C00_0010, 3);
    expect_done("jal", 16'd2);

    // LW at top of address space, then wrap
    do_start(32'hFFFF_FFFC);
    send(OP_LW, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    expect_write("lw", 32'hFFFF_FFFC, 32'h8FA8_0004, 0);
    check("lw_wrap", mem_addr, 32'h0000_0000);
    send(OP_SW, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b1);
    expect_write("sw0", 32'h0000_0000, 32'hAC00_0000, 0);
    expect_done("wrap", 16'd2);

    // Remaining I-type ops, immediate passed through raw
    do_start(32'h0000_0100);
    for (int i = 0; i < 6; i++) begin
      send(iv[i].op, iv[i].rs, iv[i].rt, 5'd0, 6'd0, iv[i].imm, 26'd0,
           i == 5);
      expect_write($sformatf("itype%0d", i), 32'h100 + 32'(i) * 4,
                   iv[i].w, i % 2);
    end
    expect_done("itype", 16'd6);

    // Illegal op 13
    do_start(32'h0000_3000);
    send(4'd13, 5'd1, 5'd2, 5'd3, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b1);
`ifdef ENC_ILLEGAL_CHECK_EN
    check("ill_we", {31'd0, mem_we}, 32'd0);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_addr", mem_addr, 32'h0000_3000);
    expect_done("ill", 16'd0);
    check("ill_err_sticky", {31'd0, err}, 32'd1);
    do_start(32'h0000_3100);
    check("ill_err_clr", {31'd0, err}, 32'd0);
    send(OP_ADDI, 5'd0, 5'd0, 5'd0, 6'd0, 16'h1, 26'd0, 1'b1);
    expect_write("ill_after", 32'h0000_3100, 32'h2000_0001, 0);
    expect_done("ill_after", 16'd1);
`else
    expect_write("ill", 32'h0000_3000, 32'h0000_0000, 0);
    check("ill_err", {31'd0, err}, 32'd0);
    expect_done("ill", 16'd1);
`endif

    // Reset in the middle of a write
    do_start(32'h0000_4000);
    send(OP_ADDI, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0007, 26'd0, 1'b0);
    check("rw_we", {31'd0, mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_we_drop", {31'd0, mem_we}, 32'd0);
    check("rw_busy_drop", {31'd0, busy}, 32'd0);
    check("rw_addr", mem_addr, 32'd0);
    check("rw_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rw_idle", {31'd0, busy}, 32'd0);
    do_start(32'h0000_5000);
    send(OP_ORI, 5'd2, 5'd3, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b1);
    expect_write("rw_new", 32'h0000_5000, 32'h3443_00FF, 0);
    expect_done("rw_new", 16'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
